// File: rtl/mc_controller.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and memory port, with memory-ready stalls and an illegal-op trap.
module mc_controller #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       pc_write, mem_write, ir_write, reg_write;
    logic [2:0] func_alu;
    logic       func_ok;

    // ALU function for EXECUTER/EXECUTEI; only R-type honours funct7b5 for sub.
    always_comb begin
        func_alu = 3'b000;
        func_ok  = 1'b1;
        case (funct3)
            3'b000:  func_alu = (state_q == S_EXECUTER && funct7b5) ? 3'b001 : 3'b000;
            3'b010:  func_alu = 3'b101;
            3'b110:  func_alu = 3'b011;
            3'b111:  func_alu = 3'b010;
            default: func_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        ALUControl = 3'b000;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW:   begin ImmSrc = 2'b00; state_d = S_MEMADR; end
                    OP_SW:   begin ImmSrc = 2'b01; state_d = S_MEMADR; end
                    OP_R:    state_d = S_EXECUTER;
                    OP_I:    state_d = S_EXECUTEI;
                    OP_BEQ:  begin ImmSrc = 2'b10; state_d = (funct3 == 3'b000) ? S_BEQ : S_TRAP; end
                    OP_JAL:  begin ImmSrc = 2'b11; state_d = S_JAL; end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (op == OP_SW) ? 2'b01 : 2'b00;
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = 2'b10;
                ALUControl = func_alu;
                state_d    = func_ok ? S_ALUWB : S_TRAP;
            end
            S_EXECUTEI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = func_alu;
                state_d    = func_ok ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = 2'b10;
                ALUControl = 3'b001;
                ImmSrc     = 2'b10;
                pc_write   = Zero;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                ImmSrc   = 2'b11;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= state_t'(RESET_STATE);
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Architectural strobes are suppressed for as long as reset is held.
    assign PCWrite  = pc_write  & ~reset;
    assign MemWrite = mem_write & ~reset;
    assign IRWrite  = ir_write  & ~reset;
    assign RegWrite = reg_write & ~reset;
    assign Illegal  = illegal_q;
    assign State    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller: per-instruction expected
// state traces and per-state output tables are built from the instruction rules.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, Zero, MemReady;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int errs = 0;
    int checks = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    mc_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    logic [20:0] act;
    assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State};

    // Output table straight from the per-state description.
    function automatic logic [20:0] exp_vec(int st, logic mr, logic z, logic [6:0] o,
                                            logic [2:0] f3, logic f7);
        logic pc, adr, mw, ir, rw, il;
        logic [1:0] rs, sa, sb, imm;
        logic [2:0] alu, fn;
        pc = 0; adr = 0; mw = 0; ir = 0; rw = 0; il = 0;
        rs = 0; sa = 0; sb = 0; imm = 0; alu = 0;
        case (f3)
            3'b000:  fn = (st == 6 && f7) ? 3'b001 : 3'b000;
            3'b010:  fn = 3'b101;
            3'b110:  fn = 3'b011;
            3'b111:  fn = 3'b010;
            default: fn = 3'b000;
        endcase
        case (st)
            0:  begin sb = 2'b10; rs = 2'b10; ir = mr; pc = mr; end
            1:  begin
                    sa = 2'b01; sb = 2'b01;
                    if (o == SW) imm = 2'b01;
                    else if (o == BQ) imm = 2'b10;
                    else if (o == JL) imm = 2'b11;
                end
            2:  begin sa = 2'b10; sb = 2'b01; imm = (o == SW) ? 2'b01 : 2'b00; end
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; alu = fn; end
            7:  begin sa = 2'b10; sb = 2'b01; alu = fn; end
            8:  rw = 1;
            9:  begin sa = 2'b10; alu = 3'b001; imm = 2'b10; pc = z; end
            10: begin sa = 2'b01; sb = 2'b10; imm = 2'b11; pc = 1; end
            15: il = 1;
            default: ;
        endcase
        return {pc, adr, mw, ir, rw, rs, sa, sb, imm, alu, il, 4'(st)};
    endfunction

    // Runs one instruction through the DUT, checking every cycle, and returns
    // the state it is expected to settle in afterwards (0 or 15).
    task automatic run_instr(input string nm, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input int stall_f, input int stall_m,
                             output int final_st);
        int   sq[$];
        bit   mq[$];
        logic zb;
        bit   ok_f3;
        ok_f3 = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
        final_st = 0;
        repeat (stall_f) begin sq.push_back(0); mq.push_back(0); end
        sq.push_back(0); mq.push_back(1);
        sq.push_back(1); mq.push_back(1'($urandom));
        if (o == LW || o == SW) begin
            sq.push_back(2); mq.push_back(1'($urandom));
            repeat (stall_m) begin sq.push_back(o == LW ? 3 : 5); mq.push_back(0); end
            sq.push_back(o == LW ? 3 : 5); mq.push_back(1);
            if (o == LW) begin sq.push_back(4); mq.push_back(1'($urandom)); end
        end else if (o == RT || o == IT) begin
            sq.push_back(o == RT ? 6 : 7); mq.push_back(1'($urandom));
            if (ok_f3) begin sq.push_back(8); mq.push_back(1'($urandom)); end
            else final_st = 15;
        end else if (o == BQ && f3 == 3'b000) begin
            sq.push_back(9); mq.push_back(1'($urandom));
        end else if (o == JL) begin
            sq.push_back(10); mq.push_back(1'($urandom));
            sq.push_back(8);  mq.push_back(1'($urandom));
        end else final_st = 15;

        op = o; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i < sq.size(); i++) begin
            @(negedge clk);
            MemReady = mq[i];
            zb = 1'($urandom);
            Zero = zb;
            #1;
            checks++;
            if (act !== exp_vec(sq[i], mq[i], zb, o, f3, f7)) begin
                errs++;
                $display("FAIL %s cyc%0d: got %h want %h", nm, i, act,
                         exp_vec(sq[i], mq[i], zb, o, f3, f7));
            end
        end
        @(negedge clk);
        MemReady = 1'b0;
        Zero = 1'($urandom);
        #1;
        checks++;
        if (act !== exp_vec(final_st, 1'b0, Zero, o, f3, f7)) begin
            errs++;
            $display("FAIL %s end: got %h want %h", nm, act, exp_vec(final_st, 1'b0, Zero, o, f3, f7));
        end
    endtask

    task automatic test_reset();
        int fs;
        reset = 1; MemReady = 1; Zero = 0; op = 0; funct3 = 0; funct7b5 = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({State, Illegal, PCWrite, IRWrite, MemWrite, RegWrite} !== 10'b0) begin
            errs++;
            $display("FAIL reset_hold: got %b want 0", {State, Illegal, PCWrite, IRWrite, MemWrite, RegWrite});
        end
        @(negedge clk);
        reset = 0; MemReady = 0;
        #1;
        checks++;
        if ({State, Illegal, PCWrite, IRWrite, MemWrite, RegWrite} !== 10'b0) begin
            errs++;
            $display("FAIL reset_after: got %b want 0", {State, Illegal, PCWrite, IRWrite, MemWrite, RegWrite});
        end
        // Abandon a load in MEMWB: RegWrite must be masked during reset.
        op = LW; funct3 = 3'b010;
        repeat (4) begin @(negedge clk); MemReady = 1; end
        @(negedge clk);
        reset = 1;
        #1;
        checks++;
        if ({State, RegWrite} !== {4'd4, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid: got st=%0d rw=%b want st=4 rw=0", State, RegWrite);
        end
        @(negedge clk);
        reset = 0; MemReady = 0;
        #1;
        checks++;
        if ({State, PCWrite, IRWrite, MemWrite, RegWrite} !== 8'b0) begin
            errs++;
            $display("FAIL reset_mid_after: got st=%0d strobes=%b want 0", State,
                     {PCWrite, IRWrite, MemWrite, RegWrite});
        end
        run_instr("add_after_reset", RT, 3'b000, 1'b0, 0, 0, fs);
    endtask

    task automatic test_alu();
        int fs;
        run_instr("add", RT, 3'b000, 1'b0, 0, 0, fs);
        run_instr("sub", RT, 3'b000, 1'b1, 0, 0, fs);
        run_instr("addi_f7", IT, 3'b000, 1'b1, 0, 0, fs);
        run_instr("slt", RT, 3'b010, 1'b0, 1, 0, fs);
        run_instr("ori", IT, 3'b110, 1'($urandom), 0, 0, fs);
        run_instr("and", RT, 3'b111, 1'($urandom), 2, 0, fs);
    endtask

    task automatic test_mem();
        int fs;
        run_instr("lw_stall2", LW, 3'b010, 1'b0, 0, 2, fs);
        run_instr("lw", LW, 3'b010, 1'b0, 0, 0, fs);
        run_instr("sw_stall1", SW, 3'b010, 1'b0, 0, 1, fs);
        run_instr("sw", SW, 3'b010, 1'b0, 1, 0, fs);
    endtask

    task automatic test_branch_jal();
        int fs;
        run_instr("beq_a", BQ, 3'b000, 1'b0, 0, 0, fs);
        run_instr("beq_b", BQ, 3'b000, 1'b0, 0, 0, fs);
        run_instr("jal", JL, 3'b000, 1'b0, 0, 0, fs);
    endtask

    task automatic test_illegal();
        logic [6:0] ops [3] = '{7'b0000000, RT, BQ};
        logic [2:0] f3s [3] = '{3'b000, 3'b001, 3'b001};
        int fs;
        for (int k = 0; k < 3; k++) begin
            run_instr("trap_entry", ops[k], f3s[k], 1'b0, 0, 0, fs);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                MemReady = 1'($urandom); Zero = 1'($urandom);
                #1;
                checks++;
                if (act !== exp_vec(15, MemReady, Zero, ops[k], f3s[k], 1'b0)) begin
                    errs++;
                    $display("FAIL trap_hold k%0d c%0d: got %h want %h", k, c, act,
                             exp_vec(15, MemReady, Zero, ops[k], f3s[k], 1'b0));
                end
            end
            @(negedge clk);
            reset = 1; MemReady = 1;
            @(negedge clk);
            reset = 0; MemReady = 0;
            #1;
            checks++;
            if ({State, Illegal} !== 5'b0) begin
                errs++;
                $display("FAIL trap_clear k%0d: got st=%0d il=%b want 0/0", k, State, Illegal);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [6] = '{LW, SW, RT, IT, BQ, JL};
        logic [2:0] f3s [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
        logic [6:0] o;
        logic [2:0] f3;
        int fs;
        for (int n = 0; n < 40; n++) begin
            o  = ops[$urandom_range(0, 5)];
            f3 = (o == BQ) ? 3'b000 : f3s[$urandom_range(0, 3)];
            run_instr("b2b", o, f3, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), fs);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch_jal();
        test_illegal();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
